// File: rtl/popcnt_frame_ctrl.sv
// -----------------------------------------------------------------------------
// popcnt_frame_ctrl
//
// Frame sequencer for the 4-lane stochastic popcount adder. It accepts a frame
// request and gates one 128-bit word group per cycle from the Sobol generator
// into the adder. It also accumulates the adder's scaled counts into a
// saturating frame result. Lane data bypasses this block; only control and
// the result pass through it.
//
// Parameters
//   ACC_W        accumulator/result width (>= 9)
//   LEN_W        frame_len width; a frame holds 1..2^LEN_W words
//
// Ports
//   clk          clock, all state changes on posedge
//   rst          asynchronous active-low reset
//   start_i      frame request, sampled only in IDLE
//   frame_len_i  words in the frame (0 means 2^LEN_W), latched with start_i
//   abort_i      synchronous cancel of the running frame
//   s_valid_i    generator presents a word group on the adder lanes
//   s_ready_o    controller accepts a word group this cycle
//   add_en_o     adder en_in, s_valid_i & s_ready_o
//   add_out_i    adder result, 2 x popcount (0..256)
//   add_en_out_i adder result valid, one cycle after add_en_o
//   busy_o       frame in progress (RUN or DRAIN)
//   done_o       one-cycle pulse, result_o is final
//   result_o     saturating sum of add_out_i over the frame
//   sat_o        result saturated during the current or last frame
// -----------------------------------------------------------------------------
module popcnt_frame_ctrl #(
   parameter int ACC_W = 16,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [LEN_W-1:0] frame_len_i,
   input  logic             abort_i,
   input  logic             s_valid_i,
   output logic             s_ready_o,
   output logic             add_en_o,
   input  logic [8:0]       add_out_i,
   input  logic             add_en_out_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [ACC_W-1:0] result_o,
   output logic             sat_o
);

   // One extra bit so a full 2^LEN_W frame is representable without wrap.
   localparam int CNT_W = LEN_W + 1;
   localparam logic [CNT_W-1:0] FULL_LEN = {1'b1, {LEN_W{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
   logic [ACC_W-1:0] result_q, result_d;
   logic             sat_q, sat_d;

   logic             ret_fire;
   logic [ACC_W:0]   sum;

   assign s_ready_o = (state_q == S_RUN);
   assign add_en_o  = s_valid_i & s_ready_o;
   assign busy_o    = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done_o    = (state_q == S_DONE);
   assign result_o  = result_q;
   assign sat_o     = sat_q;

   // Returns only count while a frame is live; the adder holds its output
   // when idle, so a stray or post-abort add_en_out_i must not be absorbed.
   assign ret_fire = add_en_out_i && busy_o;
   assign sum      = {1'b0, result_q} + (ACC_W+1)'(add_out_i);

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      issue_cnt_d = issue_cnt_q;
      ret_cnt_d   = ret_cnt_q;
      result_d    = result_q;
      sat_d       = sat_q;

      if (ret_fire) begin
         ret_cnt_d = ret_cnt_q + CNT_W'(1);
         if (sum[ACC_W]) begin
            result_d = '1;
            sat_d    = 1'b1;
         end else begin
            result_d = sum[ACC_W-1:0];
         end
      end

      case (state_q)
         S_IDLE: begin
            // start wins over a simultaneous abort: abort has no meaning here.
            if (start_i) begin
               len_d       = (frame_len_i == '0) ? FULL_LEN : {1'b0, frame_len_i};
               issue_cnt_d = '0;
               ret_cnt_d   = '0;
               result_d    = '0;
               sat_d       = 1'b0;
               state_d     = S_RUN;
            end
         end
         S_RUN: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (add_en_o) begin
               issue_cnt_d = issue_cnt_q + CNT_W'(1);
               if (issue_cnt_d == len_q) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            // ret_cnt_d already includes a return landing on this edge.
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (ret_cnt_d == len_q) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         issue_cnt_q <= '0;
         ret_cnt_q   <= '0;
         result_q    <= '0;
         sat_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         issue_cnt_q <= issue_cnt_d;
         ret_cnt_q   <= ret_cnt_d;
         result_q    <= result_d;
         sat_q       <= sat_d;
      end
   end

endmodule

// File: tb/tb_popcnt_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_popcnt_frame_ctrl
//
// Directed testbench for popcnt_frame_ctrl. A small behavioural adder model
// registers add_en_o into add_en_out_i and 2 x lane popcount into add_out_i,
// one cycle after the enable, as the real adder does. Each scenario task
// drives its own stimulus and compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_popcnt_frame_ctrl;

   localparam int ACC_W = 16;
   localparam int LEN_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start_i = 1'b0;
   logic [LEN_W-1:0] frame_len_i = '0;
   logic             abort_i = 1'b0;
   logic             s_valid_i = 1'b0;
   logic             s_ready_o;
   logic             add_en_o;
   logic [8:0]       add_out_i;
   logic             add_en_out_i;
   logic             busy_o;
   logic             done_o;
   logic [ACC_W-1:0] result_o;
   logic             sat_o;

   int n_checks = 0;
   int n_err    = 0;
   int edge_n   = 0;
   int start_edge = 0;

   // adder model
   int         lane_pc = 0;
   logic       model_en_q = 1'b0;
   logic [8:0] model_out_q = '0;
   logic       stray_en = 1'b0;
   logic [8:0] stray_val = '0;

   // per-frame observations
   bit valid_pat [0:15];
   int pc_pat    [0:15];
   int r_xfers, r_last, r_done_cnt, r_done_edge, r_aen_cnt;
   logic r_busy_at_done;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      model_en_q <= add_en_o;
      if (add_en_o) model_out_q <= 9'(2 * lane_pc);
   end
   assign add_en_out_i = model_en_q | stray_en;
   assign add_out_i    = stray_en ? stray_val : model_out_q;

   popcnt_frame_ctrl #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .frame_len_i  (frame_len_i),
      .abort_i      (abort_i),
      .s_valid_i    (s_valid_i),
      .s_ready_o    (s_ready_o),
      .add_en_o     (add_en_o),
      .add_out_i    (add_out_i),
      .add_en_out_i (add_en_out_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .result_o     (result_o),
      .sat_o        (sat_o)
   );

   task automatic step();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic start_frame(input int len);
      start_i     = 1'b1;
      frame_len_i = LEN_W'(len);
      step();
      start_i    = 1'b0;
      start_edge = edge_n;
   endtask

   task automatic set_pc(input int v);
      for (int k = 0; k < 16; k++) pc_pat[k] = v;
   endtask

   // Stimulus driver: plays the s_valid pattern (then holds 'hold'), feeds lane
   // popcounts per transfer, optionally pokes start during RUN, and records the
   // transfer/done timeline. Stops once done falls or the budget expires.
   task automatic run_frame(input int npat, input bit hold, input int budget, input bit poke);
      r_xfers = 0; r_last = -1; r_done_cnt = 0; r_done_edge = -1; r_aen_cnt = 0;
      r_busy_at_done = 1'bx;
      for (int c = 0; c < budget; c++) begin
         s_valid_i = (c < npat) ? valid_pat[c] : hold;
         lane_pc   = (r_xfers < 16) ? pc_pat[r_xfers] : pc_pat[15];
         if (poke) begin
            start_i     = (c == 1 || c == 2);
            frame_len_i = 8'd2;
         end
         #1;
         if (add_en_o) begin
            r_xfers++;
            r_aen_cnt++;
            r_last = edge_n + 1;
         end
         step();
         if (done_o) begin
            if (r_done_cnt == 0) begin
               r_done_edge    = edge_n;
               r_busy_at_done = busy_o;
            end
            r_done_cnt++;
         end else if (r_done_cnt > 0) begin
            break;
         end
      end
      s_valid_i = 1'b0;
      start_i   = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_checks++; if (s_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_s_ready: got %b want 0", s_ready_o); end
      n_checks++; if (add_en_o !== 1'b0) begin n_err++; $display("FAIL reset_add_en: got %b want 0", add_en_o); end
      n_checks++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      n_checks++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done_o); end
      n_checks++; if (result_o !== 16'd0) begin n_err++; $display("FAIL reset_result: got %0d want 0", result_o); end
      n_checks++; if (sat_o !== 1'b0) begin n_err++; $display("FAIL reset_sat: got %b want 0", sat_o); end
      step();
      #2 rst = 1'b1;
      step();
      $display("reset: released, busy=%b result=%0d", busy_o, result_o);
   endtask

   task automatic test_basic();
      set_pc(128);
      start_frame(4);
      n_checks++; if (s_ready_o !== 1'b1) begin n_err++; $display("FAIL basic_s_ready_latency: got %b want 1", s_ready_o); end
      run_frame(0, 1'b1, 20, 1'b0);
      $display("basic: xfers=%0d result=%0d sat=%b done_edge=%0d last=%0d", r_xfers, result_o, sat_o, r_done_edge, r_last);
      n_checks++; if (r_xfers !== 4) begin n_err++; $display("FAIL basic_xfers: got %0d want 4", r_xfers); end
      n_checks++; if (result_o !== 16'd1024) begin n_err++; $display("FAIL basic_result: got %0d want 1024", result_o); end
      n_checks++; if (sat_o !== 1'b0) begin n_err++; $display("FAIL basic_sat: got %b want 0", sat_o); end
      n_checks++; if (r_done_cnt !== 1) begin n_err++; $display("FAIL basic_done_cycles: got %0d want 1", r_done_cnt); end
      n_checks++; if (r_done_edge !== r_last + 1) begin n_err++; $display("FAIL basic_done_timing: got edge %0d want %0d", r_done_edge, r_last + 1); end
      n_checks++; if (r_busy_at_done !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done: got %b want 0", r_busy_at_done); end
   endtask

   task automatic test_min_frame();
      set_pc(3);
      start_frame(1);
      run_frame(0, 1'b1, 10, 1'b0);
      $display("min: xfers=%0d result=%0d done_edge=%0d start=%0d", r_xfers, result_o, r_done_edge, start_edge);
      n_checks++; if (r_last !== start_edge + 1) begin n_err++; $display("FAIL min_xfer_edge: got %0d want %0d", r_last, start_edge + 1); end
      n_checks++; if (r_done_edge !== start_edge + 2) begin n_err++; $display("FAIL min_done_edge: got %0d want %0d", r_done_edge, start_edge + 2); end
      n_checks++; if (result_o !== 16'd6) begin n_err++; $display("FAIL min_result: got %0d want 6", result_o); end
   endtask

   task automatic test_backpressure();
      bit pat [0:5];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int k = 0; k < 6; k++) valid_pat[k] = pat[k];
      set_pc(0);
      pc_pat[0] = 10; pc_pat[1] = 20; pc_pat[2] = 30;
      start_frame(3);
      run_frame(6, 1'b0, 20, 1'b0);
      $display("backpressure: add_en=%0d result=%0d done_edge=%0d last=%0d", r_aen_cnt, result_o, r_done_edge, r_last);
      n_checks++; if (r_aen_cnt !== 3) begin n_err++; $display("FAIL bp_add_en_cycles: got %0d want 3", r_aen_cnt); end
      n_checks++; if (result_o !== 16'd120) begin n_err++; $display("FAIL bp_result: got %0d want 120", result_o); end
      n_checks++; if (r_last !== start_edge + 6) begin n_err++; $display("FAIL bp_last_xfer: got %0d want %0d", r_last, start_edge + 6); end
      n_checks++; if (r_done_edge !== r_last + 1) begin n_err++; $display("FAIL bp_done_timing: got %0d want %0d", r_done_edge, r_last + 1); end
   endtask

   task automatic test_saturation();
      set_pc(128);
      start_frame(0);
      run_frame(0, 1'b1, 300, 1'b0);
      $display("saturation: xfers=%0d result=%0h sat=%b done=%0d", r_xfers, result_o, sat_o, r_done_cnt);
      n_checks++; if (r_xfers !== 256) begin n_err++; $display("FAIL sat_xfers: got %0d want 256", r_xfers); end
      n_checks++; if (result_o !== 16'hFFFF) begin n_err++; $display("FAIL sat_result: got %0h want ffff", result_o); end
      n_checks++; if (sat_o !== 1'b1) begin n_err++; $display("FAIL sat_flag: got %b want 1", sat_o); end
      n_checks++; if (r_done_cnt !== 1) begin n_err++; $display("FAIL sat_done: got %0d want 1", r_done_cnt); end
      start_frame(1);
      n_checks++; if (sat_o !== 1'b0) begin n_err++; $display("FAIL sat_cleared_by_start: got %b want 0", sat_o); end
      set_pc(1);
      run_frame(0, 1'b1, 10, 1'b0);
   endtask

   task automatic test_abort();
      int pcs [0:4];
      int dcnt;
      pcs = '{10, 20, 30, 0, 50};
      start_frame(8);
      for (int k = 0; k < 5; k++) begin
         s_valid_i = 1'b1;
         lane_pc   = pcs[k];
         abort_i   = (k == 4);
         step();
      end
      abort_i   = 1'b0;
      s_valid_i = 1'b0;
      n_checks++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy_o); end
      n_checks++; if (s_ready_o !== 1'b0) begin n_err++; $display("FAIL abort_s_ready: got %b want 0", s_ready_o); end
      dcnt = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (done_o) dcnt++;
      end
      $display("abort: result=%0d done_cycles=%0d", result_o, dcnt);
      n_checks++; if (dcnt !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d want 0", dcnt); end
      n_checks++; if (result_o !== 16'd120) begin n_err++; $display("FAIL abort_partial: got %0d want 120", result_o); end
      start_frame(1);
      n_checks++; if (result_o !== 16'd0) begin n_err++; $display("FAIL abort_restart_clear: got %0d want 0", result_o); end
      set_pc(7);
      run_frame(0, 1'b1, 10, 1'b0);
      n_checks++; if (result_o !== 16'd14) begin n_err++; $display("FAIL abort_restart_result: got %0d want 14", result_o); end
   endtask

   task automatic test_start_busy_stray();
      set_pc(25);
      start_frame(4);
      run_frame(0, 1'b1, 20, 1'b1);
      $display("start_busy: xfers=%0d result=%0d", r_xfers, result_o);
      n_checks++; if (r_xfers !== 4) begin n_err++; $display("FAIL busy_start_len: got %0d want 4", r_xfers); end
      n_checks++; if (result_o !== 16'd200) begin n_err++; $display("FAIL busy_start_result: got %0d want 200", result_o); end
      stray_val = 9'd100;
      stray_en  = 1'b1;
      step();
      stray_en  = 1'b0;
      step();
      $display("stray: result=%0d busy=%b", result_o, busy_o);
      n_checks++; if (result_o !== 16'd200) begin n_err++; $display("FAIL stray_result: got %0d want 200", result_o); end
      n_checks++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL stray_busy: got %b want 0", busy_o); end
   endtask

   task automatic test_async_reset();
      set_pc(5);
      start_frame(4);
      for (int k = 0; k < 4; k++) begin
         s_valid_i = 1'b1;
         lane_pc   = 5;
         step();
      end
      n_checks++; if (busy_o !== 1'b1 || s_ready_o !== 1'b0) begin n_err++; $display("FAIL ar_in_drain: got busy=%b s_ready=%b want 1/0", busy_o, s_ready_o); end
      n_checks++; if (result_o !== 16'd30) begin n_err++; $display("FAIL ar_pre_result: got %0d want 30", result_o); end
      #2 rst = 1'b0;
      #1;
      n_checks++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL ar_busy: got %b want 0", busy_o); end
      n_checks++; if (result_o !== 16'd0) begin n_err++; $display("FAIL ar_result: got %0d want 0", result_o); end
      n_checks++; if (done_o !== 1'b0 || sat_o !== 1'b0 || add_en_o !== 1'b0) begin n_err++; $display("FAIL ar_flags: got done=%b sat=%b add_en=%b want 0", done_o, sat_o, add_en_o); end
      s_valid_i = 1'b0;
      step();
      #2 rst = 1'b1;
      step();
      set_pc(9);
      start_frame(2);
      run_frame(0, 1'b1, 20, 1'b0);
      $display("async_reset: recovery result=%0d done=%0d", result_o, r_done_cnt);
      n_checks++; if (result_o !== 16'd36) begin n_err++; $display("FAIL ar_recover_result: got %0d want 36", result_o); end
      n_checks++; if (r_done_cnt !== 1) begin n_err++; $display("FAIL ar_recover_done: got %0d want 1", r_done_cnt); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_min_frame();
      test_backpressure();
      test_saturation();
      test_abort();
      test_start_busy_stray();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/popcnt_frame_ctrl.md
# popcnt_frame_ctrl

Frame sequencer for the 4-lane stochastic popcount adder in the Sobol bitstream datapath. It accepts a frame request, gates one 128-bit bitstream word group per cycle from the Sobol generator into the adder, and accumulates the adder's scaled counts into a frame result. It sits between the generator's valid/ready stream and the adder's en_in/en_out pair. Lane data goes straight from the generator to the adder; this block carries only control and result.

## Interface
- ACC_W, 16: accumulator/result width; must be ≥ 9.
- LEN_W, 8: frame_len width; a frame holds 1..2^LEN_W words.
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  frame request; sampled only in IDLE.
- frame_len  in  LEN_W  words in the frame, latched with start; 0 means 2^LEN_W.
- abort  in  1  synchronous cancel of the current frame.
- s_valid  in  1  generator has a word group on the adder lane inputs.
- s_ready  out  1  controller accepts a word group this cycle.
- add_en  out  1  drives adder en_in; combinational, equal to s_valid & s_ready.
- add_out  in  9  adder result: 2 × popcount of the 128 lane bits, range 0..256.
- add_en_out  in  1  adder result valid; registered, one cycle after add_en.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the frame result is final.
- result  out  ACC_W  saturating sum of add_out over the frame.
- sat  out  1  result saturated during the current or last frame.

## Operation
- States are IDLE, RUN, DRAIN and DONE.
- IDLE:
  - start=1 latches frame_len (0 maps to 2^LEN_W).
  - Same edge: clears result, sat, issue_cnt and ret_cnt, then moves to RUN.
- RUN:
  - s_ready=1.
  - A transfer is s_valid&s_ready; each transfer increments issue_cnt.
  - When a transfer makes issue_cnt equal to len, s_ready drops next cycle and the state moves to DRAIN.
- DRAIN:
  - s_ready=0 and add_en=0.
  - When ret_cnt equals len (counting the current edge's return), move to DONE.
- DONE: lasts one cycle with done=1, then returns to IDLE.
- Return path (RUN and DRAIN only):
  - On add_en_out=1, result ← result + add_out, saturating at 2^ACC_W−1.
  - Saturation sets sat; sat is sticky until the next start.
  - ret_cnt increments on each add_en_out.
- add_en_out in IDLE or DONE is ignored. The adder holds out when en_in is low, so only add_en_out qualifies data.
- result and sat hold their values in IDLE until the next accepted start.
- abort in RUN or DRAIN:
  - Returns to IDLE on that edge; no done pulse.
  - result keeps its partial value.
  - In-flight add_en_out after the abort is ignored.
  - abort in IDLE/DONE has no effect; abort together with start in IDLE means start wins.
- start outside IDLE is ignored, with no queuing.
- Counter widths: issue_cnt and ret_cnt are LEN_W+1 bits, so 2^LEN_W is representable without wrap.

## Timing
- Reset values: s_ready=0, add_en=0, busy=0, done=0, result=0, sat=0, state=IDLE, counters=0.
- Reset mid-frame returns to IDLE immediately, with no done pulse.
- start to s_ready: 1 cycle (start sampled at edge E, s_ready high from E+1).
- Throughput: one word per cycle with s_valid held high; a frame of N words occupies N cycles in RUN.
- Last transfer at edge T:
  - add_en_out is high in cycle T..T+1.
  - Accumulation happens at T+1 and DONE is entered at T+1.
  - done is high in cycle T+1..T+2.
  - result is final when done is high.
- Minimum frame (N=1, no stalls): start edge E, transfer E+1, done high in cycle E+2..E+3.
- Generator stalls (s_valid low) stretch RUN; add_en stays 0 during stalls.
- busy drops in the same cycle done rises.

## Test plan
- Basic frame:
  - Stimulus: frame_len=4, all lanes 0xFFFFFFFF, s_valid held high.
  - Required: add_out=256 ×4, result=1024, sat=0, exactly one done pulse 2 cycles after the 4th transfer.
- Backpressure:
  - Stimulus: frame_len=3, s_valid pattern 1,0,0,1,0,1; lane popcounts 10, 20, 30.
  - Required: result=120, add_en high exactly 3 cycles, done 2 cycles after the last transfer.
- Saturation:
  - Stimulus: frame_len=0 (256 words), all ones, ACC_W=16.
  - Required: result=0xFFFF, sat=1, done after 256 transfers.
- Abort mid-frame:
  - Stimulus: frame_len=8, abort after 5 transfers.
  - Required: idle next cycle, busy=0, no done; the adder's final add_en_out is ignored; result holds the partial sum; a following start clears result to 0.
- Start while busy plus stray enable:
  - Stimulus: start pulses during RUN; add_en_out pulse in IDLE.
  - Required: frame length unchanged; result unchanged by the stray pulse.
- Async reset:
  - Stimulus: rst low mid-DRAIN.
  - Required: all outputs at reset values immediately; after release, a new frame completes normally.
